fp_alu: RTL and testbench

Single-precision IEEE-754 floating-point arithmetic unit with a registered output stage. It takes two 32-bit operands and a 3-bit opcode, computes add, subtract, multiply or one of several simple sign/compare operations, and registers the result with overflow and underflow flags. It is the scalar FP execution block that sits behind the operand/opcode decode.

---
 rtl/fp_alu.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_alu.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fp_alu.sv
// Single-precision FP ALU: add/sub/mul with round-to-nearest-even, min/max,
// neg/abs, all combinational into one registered output stage.
module fp_alu #(
    parameter int WIDTH    = 32,
    parameter int MANTISSA = 23,
    parameter int EXP_BITS = WIDTH - MANTISSA - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             underflow
);
    localparam int M  = MANTISSA;
    localparam int E  = EXP_BITS;
    localparam int XW = E + 3;
    localparam int AW = M + 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MIN = 3'b010;
    localparam logic [2:0] OP_MAX = 3'b011;
    localparam logic [2:0] OP_NEG = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_ABS = 3'b110;

    localparam logic [E-1:0]          EXP_ONES = '1;
    localparam logic signed [XW-1:0]  BIAS_X   = XW'((1 << (E - 1)) - 1);
    localparam logic signed [XW-1:0]  EMAX_X   = XW'((1 << E) - 1);
    localparam logic signed [XW-1:0]  ONE_X    = XW'(1);
    localparam logic signed [XW-1:0]  ZERO_X   = '0;
    localparam logic [WIDTH-1:0]      QNAN     = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

    // Packs {overflow, underflow, word} from an unrounded normalised significand.
    function automatic logic [WIDTH+1:0] round_pack(
        input logic                 s,
        input logic signed [XW-1:0] e,
        input logic [M:0]           m,
        input logic                 g,
        input logic                 r,
        input logic                 st
    );
        logic                 up;
        logic [M+1:0]         mr;
        logic [M:0]           mf;
        logic signed [XW-1:0] ef;
        up = g & (r | st | m[0]);
        mr = {1'b0, m} + {{(M+1){1'b0}}, up};
        if (mr[M+1]) begin
            mf = mr[M+1:1];
            ef = e + ONE_X;
        end else begin
            mf = mr[M:0];
            ef = e;
        end
        if (ef >= EMAX_X)
            round_pack = {2'b10, s, EXP_ONES, {M{1'b0}}};
        else if (ef <= ZERO_X)
            round_pack = {2'b01, s, {(WIDTH-1){1'b0}}};
        else
            round_pack = {2'b00, s, ef[E-1:0], mf[M-1:0]};
    endfunction

    function automatic logic [E-1:0] lzc(input logic [AW-1:0] v);
        lzc = E'(AW);
        for (int i = 0; i < AW; i++)
            if (v[i]) lzc = E'(AW - 1 - i);
    endfunction

    logic             s_a, s_b, s_be;
    logic [E-1:0]     e_a, e_b;
    logic [M-1:0]     f_a, f_b;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [WIDTH-1:0] a_fl, b_fl;
    logic [M:0]       m_a, m_b;

    assign s_a    = A[WIDTH-1];
    assign s_b    = B[WIDTH-1];
    assign e_a    = A[WIDTH-2:M];
    assign e_b    = B[WIDTH-2:M];
    assign f_a    = A[M-1:0];
    assign f_b    = B[M-1:0];
    assign zero_a = (e_a == '0);
    assign zero_b = (e_b == '0);
    assign inf_a  = (e_a == EXP_ONES) && (f_a == '0);
    assign inf_b  = (e_b == EXP_ONES) && (f_b == '0);
    assign nan_a  = (e_a == EXP_ONES) && (f_a != '0);
    assign nan_b  = (e_b == EXP_ONES) && (f_b != '0);
    assign a_fl   = zero_a ? {s_a, {(WIDTH-1){1'b0}}} : A;
    assign b_fl   = zero_b ? {s_b, {(WIDTH-1){1'b0}}} : B;
    assign m_a    = {1'b1, f_a};
    assign m_b    = {1'b1, f_b};
    assign s_be   = s_b ^ (sel == OP_SUB);

    // Multiply path
    logic [2*M+1:0]       prod;
    logic                 mul_s, mul_g, mul_r, mul_st;
    logic [M:0]           mul_m;
    logic signed [XW-1:0] mul_e;
    logic [WIDTH+1:0]     mul_out;

    always_comb begin
        mul_s  = s_a ^ s_b;
        prod   = {{(M+1){1'b0}}, m_a} * {{(M+1){1'b0}}, m_b};
        mul_e  = $signed({3'b000, e_a}) + $signed({3'b000, e_b}) - BIAS_X;
        if (prod[2*M+1]) begin
            mul_m  = prod[2*M+1:M+1];
            mul_g  = prod[M];
            mul_r  = prod[M-1];
            mul_st = |prod[M-2:0];
            mul_e  = mul_e + ONE_X;
        end else begin
            mul_m  = prod[2*M:M];
            mul_g  = prod[M-1];
            mul_r  = prod[M-2];
            mul_st = |prod[M-3:0];
        end
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b))
            mul_out = {2'b00, QNAN};
        else if (inf_a || inf_b)
            mul_out = {2'b00, mul_s, EXP_ONES, {M{1'b0}}};
        else if (zero_a || zero_b)
            mul_out = {2'b00, mul_s, {(WIDTH-1){1'b0}}};
        else
            mul_out = round_pack(mul_s, mul_e, mul_m, mul_g, mul_r, mul_st);
    end

    // Add/subtract path; significands carry 3 extra bits for guard/round/sticky
    logic                 a_big, eff_sub, big_s;
    logic [E-1:0]         big_e, sml_e, diff, shamt, lz;
    logic [M:0]           big_m, sml_m;
    logic [2*AW-1:0]      sh_w;
    logic [AW-1:0]        aligned, big_x, norm;
    logic [AW:0]          sum;
    logic signed [XW-1:0] add_e;
    logic [WIDTH+1:0]     add_out;

    always_comb begin
        a_big   = {e_a, f_a} >= {e_b, f_b};
        eff_sub = s_a ^ s_be;
        big_s   = a_big ? s_a : s_be;
        big_e   = a_big ? e_a : e_b;
        big_m   = a_big ? m_a : m_b;
        sml_e   = a_big ? e_b : e_a;
        sml_m   = a_big ? m_b : m_a;
        diff    = big_e - sml_e;
        shamt   = (diff > E'(AW)) ? E'(AW) : diff;
        sh_w    = {sml_m, 3'b000, {AW{1'b0}}} >> shamt;
        aligned = {sh_w[2*AW-1:AW+1], sh_w[AW] | (|sh_w[AW-1:0])};
        big_x   = {big_m, 3'b000};
        sum     = eff_sub ? ({1'b0, big_x} - {1'b0, aligned})
                          : ({1'b0, big_x} + {1'b0, aligned});
        lz      = lzc(sum[AW-1:0]);
        if (sum[AW]) begin
            norm  = {sum[AW:2], sum[1] | sum[0]};
            add_e = $signed({3'b000, big_e}) + ONE_X;
        end else begin
            norm  = sum[AW-1:0] << lz;
            add_e = $signed({3'b000, big_e}) - $signed({3'b000, lz});
        end
        if (nan_a || nan_b || (inf_a && inf_b && eff_sub))
            add_out = {2'b00, QNAN};
        else if (inf_a)
            add_out = {2'b00, s_a, EXP_ONES, {M{1'b0}}};
        else if (inf_b)
            add_out = {2'b00, s_be, EXP_ONES, {M{1'b0}}};
        else if (zero_a && zero_b)
            add_out = {2'b00, s_a & s_be, {(WIDTH-1){1'b0}}};
        else if (zero_a)
            add_out = {2'b00, s_be, B[WIDTH-2:0]};
        else if (zero_b)
            add_out = {2'b00, A};
        else if (sum == '0)
            add_out = '0;
        else
            add_out = round_pack(big_s, add_e, norm[AW-1:3], norm[2], norm[1], norm[0]);
    end

    // Ordered compare on flushed operands; sign-magnitude with -0 < +0
    logic a_lt_b;
    always_comb begin
        if (a_fl[WIDTH-1] != b_fl[WIDTH-1])
            a_lt_b = a_fl[WIDTH-1];
        else if (!a_fl[WIDTH-1])
            a_lt_b = a_fl[WIDTH-2:0] < b_fl[WIDTH-2:0];
        else
            a_lt_b = a_fl[WIDTH-2:0] > b_fl[WIDTH-2:0];
    end

    logic [WIDTH-1:0] result_d, result_q;
    logic             ovf_d, ovf_q, unf_d, unf_q;

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        case (sel)
            OP_ADD, OP_SUB: {ovf_d, unf_d, result_d} = add_out;
            OP_MUL:         {ovf_d, unf_d, result_d} = mul_out;
            OP_MIN, OP_MAX: begin
                if (nan_a && nan_b)   result_d = QNAN;
                else if (nan_a)       result_d = b_fl;
                else if (nan_b)       result_d = a_fl;
                else if (sel == OP_MIN) result_d = a_lt_b ? a_fl : b_fl;
                else                  result_d = a_lt_b ? b_fl : a_fl;
            end
            OP_NEG:  result_d = {~A[WIDTH-1], A[WIDTH-2:0]};
            OP_ABS:  result_d = {1'b0, A[WIDTH-2:0]};
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_fp_alu.sv
// Directed-vector bench for fp_alu: table of hand-computed results plus
// sequences for reset, latency and back-to-back behaviour.
module tb_fp_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] A, B;
    logic [2:0]  sel;
    logic [31:0] result;
    logic        overflow, underflow;

    int n_pass  = 0;
    int n_total = 0;

    fp_alu dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .sel(sel),
        .result(result), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] s, input logic [31:0] a, b, r,
                                input logic ov, un);
        vec_t v;
        v.sel = s; v.a = a; v.b = b; v.res = r; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] er, input logic eo, eu);
        n_total++;
        if (result !== er || overflow !== eo || underflow !== eu)
            $display("FAIL %s: got result=%h ovf=%b unf=%b, want result=%h ovf=%b unf=%b",
                     nm, result, overflow, underflow, er, eo, eu);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [2:0] s, input logic [31:0] a, b);
        @(negedge clk);
        sel = s; A = a; B = b;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; A = 32'h41234021; B = 32'h40214021; sel = 3'b101;
        repeat (3) @(posedge clk);
        #1 chk("reset_hold", 32'h0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0; sel = 3'b101; A = 32'h3FC00000; B = 32'h40000000;
        @(posedge clk); #1 chk("first_after_reset", 32'h40400000, 1'b0, 1'b0);

        vecs.push_back(mk(3'b101, 32'h00000000, 32'h41234123, 32'h00000000, 0, 0));
        vecs.push_back(mk(3'b000, 32'h3F800000, 32'h3F800000, 32'h40000000, 0, 0));
        vecs.push_back(mk(3'b001, 32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0));
        vecs.push_back(mk(3'b000, 32'h3F800000, 32'h3F000000, 32'h3FC00000, 0, 0));
        vecs.push_back(mk(3'b001, 32'h3F800000, 32'h3F000000, 32'h3F000000, 0, 0));
        vecs.push_back(mk(3'b000, 32'h3F800000, 32'hBF800000, 32'h00000000, 0, 0));
        vecs.push_back(mk(3'b101, 32'h7E007E00, 32'h7E007E00, 32'h7F800000, 1, 0));
        vecs.push_back(mk(3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1, 0));
        vecs.push_back(mk(3'b101, 32'h0F463821, 32'h0E400854, 32'h00000000, 0, 1));
        vecs.push_back(mk(3'b001, 32'h00800001, 32'h00800000, 32'h00000000, 0, 1));
        vecs.push_back(mk(3'b101, 32'h00231023, 32'h0020C213, 32'h00000000, 0, 0));
        vecs.push_back(mk(3'b101, 32'h80000001, 32'h3F800000, 32'h80000000, 0, 0));
        vecs.push_back(mk(3'b000, 32'h3F800000, 32'h33800000, 32'h3F800000, 0, 0));
        vecs.push_back(mk(3'b000, 32'h3F800001, 32'h33800000, 32'h3F800002, 0, 0));
        vecs.push_back(mk(3'b101, 32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0));
        vecs.push_back(mk(3'b101, 32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 0));
        vecs.push_back(mk(3'b001, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 0));
        vecs.push_back(mk(3'b000, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0, 0));
        vecs.push_back(mk(3'b100, 32'h3F800000, 32'h12345678, 32'hBF800000, 0, 0));
        vecs.push_back(mk(3'b100, 32'h7FC12345, 32'h00000000, 32'hFFC12345, 0, 0));
        vecs.push_back(mk(3'b110, 32'hC0000000, 32'h00000000, 32'h40000000, 0, 0));
        vecs.push_back(mk(3'b110, 32'hFFC12345, 32'h00000000, 32'h7FC12345, 0, 0));
        vecs.push_back(mk(3'b010, 32'h40000000, 32'hBF800000, 32'hBF800000, 0, 0));
        vecs.push_back(mk(3'b011, 32'h40000000, 32'hBF800000, 32'h40000000, 0, 0));
        vecs.push_back(mk(3'b010, 32'h00000000, 32'h80000000, 32'h80000000, 0, 0));
        vecs.push_back(mk(3'b011, 32'h80000000, 32'h00000000, 32'h00000000, 0, 0));
        vecs.push_back(mk(3'b010, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 0, 0));
        vecs.push_back(mk(3'b011, 32'hC0400000, 32'hC0000000, 32'hC0000000, 0, 0));
        vecs.push_back(mk(3'b111, 32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1 chk($sformatf("vec%0d_sel%b", i, vecs[i].sel), vecs[i].res, vecs[i].ov, vecs[i].un);
        end

        // Output must hold until the next edge after inputs change
        drive(3'b000, 32'h3F800000, 32'h3F800000);
        #1 chk("hold_before_edge", vecs[vecs.size()-1].res, 1'b0, 1'b0);
        @(posedge clk); #1 chk("add_after_edge", 32'h40000000, 1'b0, 1'b0);

        drive(3'b001, 32'h3F800000, 32'h3F800000);
        @(posedge clk); #1 chk("sel_only_change", 32'h00000000, 1'b0, 1'b0);

        // Back-to-back: overflow flag must not persist into the next result
        drive(3'b101, 32'h7E007E00, 32'h7E007E00);
        @(posedge clk); #1 chk("b2b_ovf", 32'h7F800000, 1'b1, 1'b0);
        drive(3'b000, 32'h3F800000, 32'h3F000000);
        @(posedge clk); #1 chk("b2b_clear", 32'h3FC00000, 1'b0, 1'b0);

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; sel = 3'b100; A = 32'h3F800000; B = 32'h0;
        @(posedge clk); #1 chk("after_async_reset", 32'hBF800000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
